i2c_bus_scheduler: RTL

- Shares one I2C_Controller instance (24-bit {slave, sub-addr, data} write transfers) among NUM_REQ requesters, e.g. the boot-time codec/decoder config sequencer, runtime volume control and a host register port.
- Round-robin arbitration.
- Per-transfer NACK retry and timeout.
- Per-requester done/error reporting.
- Runs on the system clock. Drives the controller's GO/DATA and samples its END/ACK, which are generated in the slow divided I2C control-clock domain.

---
 rtl/i2c_cfg_pkg.sv | 30 +++
 rtl/i2c_bus_scheduler_rr_arbiter.sv | 48 ++++
 rtl/i2c_bus_scheduler.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cfg_pkg.sv
// Shared configuration for the I2C bus scheduler: word width, slave
// addresses, controller clock defaults and the scheduler state encoding.
package i2c_cfg_pkg;

    // {slave, sub-address, data} write transfer
    localparam int TW = 24;

    // 8-bit write addresses of the devices on the configuration bus
    localparam logic [7:0] SLAVE_CODEC = 8'h34;
    localparam logic [7:0] SLAVE_VDEC  = 8'h40;

    // Defaults handed to I2C_Controller
    localparam int CLK_FREQ = 50_000_000;
    localparam int I2C_FREQ = 20_000;

    // Idle time between a NACKed attempt and its re-issue, in iCLK cycles
    localparam int GAP_CYC = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_ISSUE,
        ST_WAIT_LOW,
        ST_WAIT_END,
        ST_RELEASE,
        ST_GAP,
        ST_FINISH
    } sched_state_t;

endpackage

// File: rtl/i2c_bus_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational search from a registered pointer,
// with an update port that moves the pointer just past the last winner.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          upd,
    input  logic [IW-1:0] upd_idx,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] ptr;

    // Pointer moves to the requester after the one just served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (upd) begin
            ptr <= (upd_idx == IW'(N - 1)) ? '0 : upd_idx + IW'(1);
        end
    end

    // First set request at or above the pointer, wrapping around
    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/i2c_bus_scheduler.sv
// Shares one I2C_Controller between NUM_REQ requesters: round-robin grant,
// NACK retry with an idle gap, per-attempt timeout, per-requester done/error.
module i2c_bus_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int TW          = i2c_cfg_pkg::TW
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic [NUM_REQ-1:0]    iREQ,
    input  logic [NUM_REQ*TW-1:0] iDATA,
    output logic [NUM_REQ-1:0]    oGNT,
    output logic [NUM_REQ-1:0]    oDONE,
    output logic [NUM_REQ-1:0]    oERR,
    output logic                  oBUSY,
    output logic [TW-1:0]         oI2C_DATA,
    output logic                  oI2C_GO,
    input  logic                  iI2C_END,
    input  logic                  iI2C_ACK
);

    import i2c_cfg_pkg::*;

    localparam int IW    = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC);

    sched_state_t       state;
    sched_state_t       state_nxt;

    logic               end_s1;
    logic               end_s2;
    logic               end_d;
    logic               ack_s1;
    logic               ack_s2;
    logic               end_rise;

    logic [TMR_W-1:0]   timer;
    logic               timeout_hit;
    logic               gap_done;
    logic [3:0]         retry_cnt;
    logic               retry_ok;
    logic               ack_lat;
    logic               err_flag;

    logic [NUM_REQ-1:0] gnt_r;
    logic [IW-1:0]      cur_idx;
    logic [TW-1:0]      data_r;
    logic               go_r;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .clk     (iCLK),
        .rst_n   (iRST_N),
        .req     (iREQ),
        .upd     (state == ST_FINISH),
        .upd_idx (cur_idx),
        .gnt     (arb_gnt),
        .idx     (arb_idx),
        .any     (arb_any)
    );

    // END and ACK come from the divided I2C clock domain; two-flop sync each,
    // plus one more stage of END for rising-edge detection
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            end_s1 <= 1'b0;
            end_s2 <= 1'b0;
            end_d  <= 1'b0;
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
        end else begin
            end_s1 <= iI2C_END;
            end_s2 <= end_s1;
            end_d  <= end_s2;
            ack_s1 <= iI2C_ACK;
            ack_s2 <= ack_s1;
        end
    end

    assign end_rise    = end_s2 & ~end_d;
    assign timeout_hit = (timer == TMR_W'(TIMEOUT_CYC - 1));
    assign gap_done    = (timer == TMR_W'(GAP_CYC - 1));
    assign retry_ok    = (retry_cnt < 4'(MAX_RETRY));

    // State register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; timeout takes precedence over a coincident END edge
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (|iREQ) begin
                    state_nxt = ST_ARB;
                end
            end
            ST_ARB: begin
                state_nxt = arb_any ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (timeout_hit) begin
                    state_nxt = ST_FINISH;
                end else if (!end_s2) begin
                    state_nxt = ST_WAIT_END;
                end
            end
            ST_WAIT_END: begin
                if (timeout_hit) begin
                    state_nxt = ST_FINISH;
                end else if (end_rise) begin
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (ack_lat && retry_ok) begin
                    state_nxt = ST_GAP;
                end else begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant, transfer word, GO, timer/gap counter, retry count and error flag
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            gnt_r     <= '0;
            cur_idx   <= '0;
            data_r    <= '0;
            go_r      <= 1'b0;
            timer     <= '0;
            retry_cnt <= '0;
            ack_lat   <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (arb_any) begin
                        gnt_r    <= arb_gnt;
                        cur_idx  <= arb_idx;
                        data_r   <= iDATA[int'(arb_idx)*TW +: TW];
                        err_flag <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    go_r  <= 1'b1;
                    timer <= '0;
                end
                ST_WAIT_LOW: begin
                    if (timeout_hit) begin
                        go_r     <= 1'b0;
                        err_flag <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_WAIT_END: begin
                    if (timeout_hit) begin
                        go_r     <= 1'b0;
                        err_flag <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                        if (end_rise) begin
                            ack_lat <= ack_s2;
                        end
                    end
                end
                ST_RELEASE: begin
                    go_r  <= 1'b0;
                    timer <= '0;
                    if (ack_lat) begin
                        if (retry_ok) begin
                            retry_cnt <= retry_cnt + 4'd1;
                        end else begin
                            err_flag <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    timer <= timer + TMR_W'(1);
                end
                ST_FINISH: begin
                    gnt_r     <= '0;
                    retry_cnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign oGNT      = gnt_r;
    assign oDONE     = (state == ST_FINISH) ? gnt_r : '0;
    assign oERR      = (state == ST_FINISH && err_flag) ? gnt_r : '0;
    assign oBUSY     = (state != ST_IDLE);
    assign oI2C_DATA = data_r;
    assign oI2C_GO   = go_r;

endmodule
